memory_cycle: RTL
=================

# memory_cycle

Memory (M) stage of the 18-bit pipelined processor: consumes the EX/MEM register outputs of the execute stage, performs loads and stores over a req/ack data-bus handshake, and holds the MEM/WB pipeline register. Drives `StallM` to the hazard unit while a bus access is outstanding, bubbles WB meanwhile, and aborts hung accesses with a timeout counter and sticky error flag. Produces `ResultW`, the write-back value fed to the register file and the execute-stage forwarding muxes.

## Interface
- `ADDR_W`, 16: data-bus address bits taken from `ALU_ResultM[ADDR_W-1:0]`
- `TIMEOUT`, 255: max wait cycles after request before abort (1..1023)
- `clk`  in  1  clock, rising edge
- `rst`  in  1  asynchronous, active-low reset
- `RegWriteM, MemWriteM, ResultSrcM, BranchLinkM`  in  1 each  EX/MEM control
- `RD_M`  in  5  destination register
- `ALU_ResultM, WriteDataM, PCPlus4M`  in  18 each  address/ALU result, store data, link value
- `RGB_M`  in  2  bank select, driven on `mem_bank`
- `mem_req`  out  1  access request
- `mem_we`  out  1  1 = store, 0 = load
- `mem_addr`  out  ADDR_W; `mem_bank`  out  2; `mem_wdata`  out  18
- `mem_rdata`  in  18  load data, valid when `mem_ack`=1
- `mem_ack`  in  1  access complete
- `StallM`  out  1  freeze PC/IF/ID/EX/EX-MEM this cycle
- `RegWriteW`  out  1; `RD_W`  out  5
- `ALU_ResultW, ReadDataW, PCPlus4W, ResultW`  out  18 each
- `bus_error`  out  1  sticky: an access timed out

## Operation
- access = `MemWriteM | ResultSrcM`. Non-access instructions pass straight to MEM/WB in one cycle, no bus activity.
- FSM states IDLE, WAIT.
- IDLE, access=1: `mem_req`=1 combinationally; `mem_we`=`MemWriteM`, `mem_addr`/`mem_bank`/`mem_wdata` from M inputs. `mem_ack`=1 same cycle: zero-wait completion, stay IDLE. Else `StallM`=1, go WAIT, counter cleared to 0.
- WAIT: `mem_req` held 1, bus outputs from M inputs (EX/MEM held stable by `StallM`). Counter +1 per cycle. `mem_ack`=1: complete, go IDLE. Counter == TIMEOUT with no ack: abort, set `bus_error`, complete with read data 0, go IDLE. Ack and timeout same cycle: ack wins, no error.
- `StallM` = (IDLE & access & ~mem_ack) | (WAIT & ~mem_ack & ~timeout_hit).
- MEM/WB loads each cycle: if `StallM`=1, bubble (`RegWriteW`=0, other fields hold). Else M fields; `ReadDataW` = `mem_rdata` on ack, 0 on abort, unchanged for non-loads.
- Loads write only on completion; stores never write a register unless `RegWriteM` set (passed through as-is).
- ResultW = `ReadDataW` if ResultSrcW, else `PCPlus4W` if BranchLinkW, else `ALU_ResultW` (ResultSrcW, BranchLinkW internal registered copies).
- `mem_ack` while `mem_req`=0: ignored.
- `bus_error` clears only on reset.

## Timing
- Reset (async, `rst`=0): FSM IDLE, counter 0, all MEM/WB registers 0 (`RegWriteW`=0, `ResultW`=0), `bus_error`=0. `mem_req`, `StallM` are combinational from state and inputs; with EX/MEM also reset they read 0.
- Reset asserted in WAIT: request dropped immediately, no register write; access is lost.
- Latency: non-access and zero-wait accesses 1 cycle M->W. Access with ack in wait cycle k (k>=1): result in W at edge after ack; `StallM` high k cycles.
- Abort: `StallM` high TIMEOUT+1 cycles from request (request cycle plus TIMEOUT WAIT cycles; ends on the cycle where counter == TIMEOUT).
- Back-to-back accesses: next request may start the cycle after completion; no idle gap.
- Combinational paths: `mem_ack` -> `StallM`, M inputs -> bus outputs.

## Test plan
- Reset: hold `rst`=0 with `mem_ack`=1, toggling inputs -> `RegWriteW`=0, `ResultW`=0, `bus_error`=0; release, ALU op RD=3 result 0x2A -> next edge RD_W=3, ResultW=0x2A.
- Zero-wait load: ResultSrcM=1, addr 0x0010, `mem_ack`=1 same cycle, rdata 0x3FFFF -> `StallM`=0, next cycle ReadDataW=ResultW=0x3FFFF.
- Store with 3-cycle wait: MemWriteM=1, WriteDataM=0x1234, RGB_M=2 -> `mem_req`=1, `mem_we`=1, `mem_bank`=2, `StallM`=1 for 3 cycles, `RegWriteW`=0 throughout, ack -> `StallM` 0 same cycle.
- Timeout: TIMEOUT=4, load never acked -> `StallM` high 5 cycles, then `bus_error`=1 (sticky), ReadDataW=0; later acked load succeeds, `bus_error` stays 1.
- Link: BranchLinkM=1, PCPlus4M=0x105, ALU_ResultM=0x7 -> ResultW=0x105; ack on the timeout-hit cycle -> no error, rdata captured.
- Reset mid-WAIT -> `mem_req` 0 immediately, FSM IDLE, no W write.

Source files
------------

// File: rtl/memory_cycle.sv
// Memory stage of the 18-bit pipeline: bus load/store with req/ack handshake,
// wait-state stalling, timeout abort, and the MEM/WB pipeline register.
module memory_cycle #(
  parameter int ADDR_W  = 16,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              RegWriteM,
  input  logic              MemWriteM,
  input  logic              ResultSrcM,
  input  logic              BranchLinkM,
  input  logic [4:0]        RD_M,
  input  logic [17:0]       ALU_ResultM,
  input  logic [17:0]       WriteDataM,
  input  logic [17:0]       PCPlus4M,
  input  logic [1:0]        RGB_M,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [1:0]        mem_bank,
  output logic [17:0]       mem_wdata,
  input  logic [17:0]       mem_rdata,
  input  logic              mem_ack,
  output logic              StallM,
  output logic              RegWriteW,
  output logic [4:0]        RD_W,
  output logic [17:0]       ALU_ResultW,
  output logic [17:0]       ReadDataW,
  output logic [17:0]       PCPlus4W,
  output logic [17:0]       ResultW,
  output logic              bus_error
);

  localparam logic [9:0] TO = 10'(TIMEOUT);

  typedef enum logic {IDLE, WAIT} state_t;

  state_t      state;
  logic [9:0]  cnt;
  logic        access;
  logic        ack_ok;
  logic        timeout_hit;
  logic        res_src_w;
  logic        link_w;

  assign access = MemWriteM | ResultSrcM;

  // Request is gated by reset so an in-flight access drops the instant reset asserts.
  assign mem_req     = rst & (((state == IDLE) & access) | (state == WAIT));
  assign ack_ok      = mem_req & mem_ack;
  assign timeout_hit = rst & (state == WAIT) & (cnt == TO) & ~mem_ack;
  assign StallM      = mem_req & ~mem_ack & ~timeout_hit;

  assign mem_we    = MemWriteM;
  assign mem_addr  = ALU_ResultM[ADDR_W-1:0];
  assign mem_bank  = RGB_M;
  assign mem_wdata = WriteDataM;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      bus_error <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          cnt <= '0;
          if (access && !mem_ack) state <= WAIT;
        end
        WAIT: begin
          if (mem_ack || timeout_hit) begin
            state <= IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 10'd1;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
      if (timeout_hit) bus_error <= 1'b1;
    end
  end

  // MEM/WB: a stalled cycle inserts a bubble and otherwise holds its payload.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      RegWriteW   <= 1'b0;
      RD_W        <= '0;
      ALU_ResultW <= '0;
      ReadDataW   <= '0;
      PCPlus4W    <= '0;
      res_src_w   <= 1'b0;
      link_w      <= 1'b0;
    end else if (StallM) begin
      RegWriteW <= 1'b0;
    end else begin
      RegWriteW   <= RegWriteM;
      RD_W        <= RD_M;
      ALU_ResultW <= ALU_ResultM;
      PCPlus4W    <= PCPlus4M;
      res_src_w   <= ResultSrcM;
      link_w      <= BranchLinkM;
      // An unstalled load has either been acked or aborted; abort returns zero.
      if (ResultSrcM) ReadDataW <= ack_ok ? mem_rdata : 18'd0;
    end
  end

  always_comb begin
    ResultW = ALU_ResultW;
    if (res_src_w)   ResultW = ReadDataW;
    else if (link_w) ResultW = PCPlus4W;
  end

endmodule
